// File: rtl/riscv_gshare_bp.sv
// riscv_gshare_bp
//   Gshare-style branch predictor. It holds a table of 2-bit saturating
//   counters indexed by {global history, PC bits}. Each fetched PC gets a
//   registered prediction, together with the history used to form its index.
//   Resolved branches from the execute-stage branch unit write back a new
//   counter value.
//   After reset, an initialisation sweep writes weak-not-taken (01) into
//   every entry. Lookups and updates only take effect after that sweep.
//
// Ports
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   id_stall_i               decode stall; holds the prediction outputs
//   if_parcel_pc_i           lookup PC (fetch side)
//   bu_bp_history_i          lookup global history
//   ex_pc_i                  update PC (resolving branch)
//   bu_bp_history_update_i   history captured when the branch was predicted
//   bu_bp_predict_i          counter value carried with the resolving branch
//   bu_bp_btaken_i           resolved outcome
//   bu_bp_update_i           update strobe
//   bp_bp_predict_o          registered counter; bit 1 = predict taken
//   bp_bp_history_o          history registered with the prediction
//   bp_init_busy_o           high while the initialisation sweep runs
module riscv_gshare_bp #(
  parameter int XLEN           = 32,
  parameter int BP_GLOBAL_BITS = 2,
  parameter int BP_LOCAL_BITS  = 10,
  parameter int HAS_RVC        = 0
) (
  input  logic                      rst_ni,
  input  logic                      clk_i,
  input  logic                      id_stall_i,
  input  logic [XLEN-1:0]           if_parcel_pc_i,
  input  logic [BP_GLOBAL_BITS-1:0] bu_bp_history_i,
  input  logic [XLEN-1:0]           ex_pc_i,
  input  logic [BP_GLOBAL_BITS-1:0] bu_bp_history_update_i,
  input  logic [1:0]                bu_bp_predict_i,
  input  logic                      bu_bp_btaken_i,
  input  logic                      bu_bp_update_i,
  output logic [1:0]                bp_bp_predict_o,
  output logic [BP_GLOBAL_BITS-1:0] bp_bp_history_o,
  output logic                      bp_init_busy_o
);

  localparam int IDX_W = BP_GLOBAL_BITS + BP_LOCAL_BITS;
  localparam int DEPTH = 1 << IDX_W;
  localparam int OFS   = (HAS_RVC != 0) ? 1 : 2;

  typedef enum logic {INIT, RUN} state_t;

  state_t           state, state_next;
  logic [IDX_W-1:0] sweep, sweep_next;

  logic [1:0]       counters [DEPTH];

  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] up_idx;
  logic [IDX_W-1:0] wr_idx;
  logic             wr_en;
  logic [1:0]       wr_data;
  logic [1:0]       upd_value;
  logic             bypass;
  logic [1:0]       lookup_value;

  // Only a slice of each PC feeds the index. This sink keeps the other bits
  // from showing up as dangling inputs.
  logic             unused_pc_bits;
  assign unused_pc_bits = ^{if_parcel_pc_i, ex_pc_i};

  function automatic logic [1:0] sat_inc(input logic [1:0] v);
    return (v == 2'b11) ? v : v + 2'd1;
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] v);
    return (v == 2'b00) ? v : v - 2'd1;
  endfunction

  assign rd_idx = {bu_bp_history_i, if_parcel_pc_i[OFS +: BP_LOCAL_BITS]};
  assign up_idx = {bu_bp_history_update_i, ex_pc_i[OFS +: BP_LOCAL_BITS]};

  // The counter carried with the branch is authoritative. The table entry
  // is never re-read on the update path.
  assign upd_value = bu_bp_btaken_i ? sat_inc(bu_bp_predict_i)
                                    : sat_dec(bu_bp_predict_i);

  // State and sweep registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= INIT;
      sweep <= '0;
    end else begin
      state <= state_next;
      sweep <= sweep_next;
    end
  end

  // Next state and write-port steering. The sweep owns the write port while
  // in INIT, so update strobes during that time are dropped.
  always_comb begin
    state_next = state;
    sweep_next = sweep;
    wr_en      = 1'b0;
    wr_idx     = up_idx;
    wr_data    = upd_value;
    case (state)
      INIT: begin
        wr_en      = 1'b1;
        wr_idx     = sweep;
        wr_data    = 2'b01;
        sweep_next = sweep + IDX_W'(1);   // wraps to 0 after the last entry
        if (sweep == IDX_W'(DEPTH - 1)) begin
          state_next = RUN;
        end
      end
      RUN: begin
        wr_en = bu_bp_update_i;
      end
      default: begin
        state_next = INIT;
      end
    endcase
  end

  // Counter table: one write port and one read port.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      counters[wr_idx] <= wr_data;
    end
  end

  // Write-first behaviour when a lookup and an update hit the same entry.
  assign bypass       = (state == RUN) && bu_bp_update_i && (up_idx == rd_idx);
  assign lookup_value = bypass ? upd_value : counters[rd_idx];

  // Registered prediction and history. The prediction is forced to 00 during
  // the sweep and held while decode is stalled.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bp_bp_predict_o <= 2'b00;
      bp_bp_history_o <= '0;
    end else if (state == INIT) begin
      bp_bp_predict_o <= 2'b00;
      bp_bp_history_o <= '0;
    end else if (!id_stall_i) begin
      bp_bp_predict_o <= lookup_value;
      bp_bp_history_o <= bu_bp_history_i;
    end
  end

  assign bp_init_busy_o = (state == INIT);

endmodule

// File: tb/tb_riscv_gshare_bp.sv
// Directed testbench for riscv_gshare_bp with default parameters
// (2 history bits, 10 PC bits, no RVC, 4096 entries). Inputs are driven
// 1 time unit after a rising edge. Outputs are sampled at the same point,
// once the edge has taken effect.
module tb_riscv_gshare_bp;

  logic        rst_ni                 = 1'b0;
  logic        clk_i                  = 1'b0;
  logic        id_stall_i             = 1'b0;
  logic [31:0] if_parcel_pc_i         = 32'h200;
  logic [1:0]  bu_bp_history_i        = 2'd0;
  logic [31:0] ex_pc_i                = 32'h0;
  logic [1:0]  bu_bp_history_update_i = 2'd0;
  logic [1:0]  bu_bp_predict_i        = 2'd0;
  logic        bu_bp_btaken_i         = 1'b0;
  logic        bu_bp_update_i         = 1'b0;
  logic [1:0]  bp_bp_predict_o;
  logic [1:0]  bp_bp_history_o;
  logic        bp_init_busy_o;

  int n_checks = 0;
  int n_pass   = 0;

  riscv_gshare_bp dut (
    .rst_ni                 (rst_ni),
    .clk_i                  (clk_i),
    .id_stall_i             (id_stall_i),
    .if_parcel_pc_i         (if_parcel_pc_i),
    .bu_bp_history_i        (bu_bp_history_i),
    .ex_pc_i                (ex_pc_i),
    .bu_bp_history_update_i (bu_bp_history_update_i),
    .bu_bp_predict_i        (bu_bp_predict_i),
    .bu_bp_btaken_i         (bu_bp_btaken_i),
    .bu_bp_update_i         (bu_bp_update_i),
    .bp_bp_predict_o        (bp_bp_predict_o),
    .bp_bp_history_o        (bp_bp_history_o),
    .bp_init_busy_o         (bp_init_busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
      $display("ok   %-22s got 0x%0h", tag, got);
    end else begin
      $display("FAIL %-22s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic upd(input logic [31:0] pc, input logic [1:0] hist,
                     input logic [1:0] pred, input logic taken);
    ex_pc_i                = pc;
    bu_bp_history_update_i = hist;
    bu_bp_predict_i        = pred;
    bu_bp_btaken_i         = taken;
    bu_bp_update_i         = 1'b1;
  endtask

  task automatic lookup(input logic [31:0] pc, input logic [1:0] hist);
    if_parcel_pc_i  = pc;
    bu_bp_history_i = hist;
  endtask

  // Count edges until busy falls, bounded. Also count any edge where the
  // prediction was not 00.
  task automatic wait_init(output int n, output int bad_pred);
    n        = 0;
    bad_pred = 0;
    do begin
      tick();
      n++;
      if (bp_bp_predict_o !== 2'b00) bad_pred++;
    end while (bp_init_busy_o === 1'b1 && n < 5000);
  endtask

  int n_cyc;
  int n_bad;
  int n_busy_bad;

  initial begin
    // ---------------- reset state ----------------
    lookup(32'h200, 2'd0);
    tick();
    tick();
    check("rst_predict", {30'd0, bp_bp_predict_o}, 32'd0);
    check("rst_history", {30'd0, bp_bp_history_o}, 32'd0);
    check("rst_busy", {31'd0, bp_init_busy_o}, 32'd1);

    // ---------------- init sweep ----------------
    @(negedge clk_i);
    rst_ni = 1'b1;
    wait_init(n_cyc, n_bad);
    check("init_cycles", n_cyc, 4096);
    check("init_predict_zero", n_bad, 0);
    check("init_busy_low", {31'd0, bp_init_busy_o}, 32'd0);
    tick();
    check("first_predict", {30'd0, bp_bp_predict_o}, 32'd1);
    check("first_history", {30'd0, bp_bp_history_o}, 32'd0);

    // ---------------- training ----------------
    upd(32'h200, 2'd0, 2'b01, 1'b1);
    lookup(32'h204, 2'd0);
    tick();
    check("lookup_other", {30'd0, bp_bp_predict_o}, 32'd1);
    bu_bp_update_i = 1'b0;
    lookup(32'h200, 2'd0);
    tick();
    check("inc_01_to_10", {30'd0, bp_bp_predict_o}, 32'd2);

    upd(32'h200, 2'd0, 2'b10, 1'b1);
    lookup(32'h204, 2'd0);
    tick();
    bu_bp_update_i = 1'b0;
    lookup(32'h200, 2'd0);
    tick();
    check("inc_10_to_11", {30'd0, bp_bp_predict_o}, 32'd3);

    // ---------------- saturation ----------------
    upd(32'h200, 2'd0, 2'b11, 1'b1);
    tick();
    bu_bp_update_i = 1'b0;
    tick();
    check("sat_11_taken", {30'd0, bp_bp_predict_o}, 32'd3);

    upd(32'h208, 2'd0, 2'b00, 1'b0);
    lookup(32'h204, 2'd0);
    tick();
    bu_bp_update_i = 1'b0;
    lookup(32'h208, 2'd0);
    tick();
    check("sat_00_not_taken", {30'd0, bp_bp_predict_o}, 32'd0);

    upd(32'h20c, 2'd0, 2'b10, 1'b0);
    tick();
    bu_bp_update_i = 1'b0;
    lookup(32'h20c, 2'd0);
    tick();
    check("dec_10_to_01", {30'd0, bp_bp_predict_o}, 32'd1);

    upd(32'h210, 2'd0, 2'b01, 1'b0);
    tick();
    bu_bp_update_i = 1'b0;
    lookup(32'h210, 2'd0);
    tick();
    check("dec_01_to_00", {30'd0, bp_bp_predict_o}, 32'd0);

    // ---------------- bypass ----------------
    lookup(32'h300, 2'd1);
    upd(32'h300, 2'd1, 2'b01, 1'b1);
    tick();
    check("bypass_same_idx", {30'd0, bp_bp_predict_o}, 32'd2);
    check("bypass_history", {30'd0, bp_bp_history_o}, 32'd1);

    lookup(32'h304, 2'd1);
    upd(32'h300, 2'd1, 2'b10, 1'b1);
    tick();
    check("bypass_diff_idx", {30'd0, bp_bp_predict_o}, 32'd1);
    bu_bp_update_i = 1'b0;
    lookup(32'h300, 2'd1);
    tick();
    check("diff_idx_written", {30'd0, bp_bp_predict_o}, 32'd3);

    // history bits really select a different entry
    lookup(32'h300, 2'd0);
    tick();
    check("history_in_index", {30'd0, bp_bp_predict_o}, 32'd1);

    // ---------------- stall ----------------
    lookup(32'h200, 2'd0);
    tick();
    check("pre_stall", {30'd0, bp_bp_predict_o}, 32'd3);
    id_stall_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i == 0) upd(32'h400, 2'd0, 2'b01, 1'b0);
      else        bu_bp_update_i = 1'b0;
      lookup(32'h400 + 32'(i * 4), 2'(i + 1));
      tick();
      check($sformatf("stall_pred_%0d", i), {30'd0, bp_bp_predict_o}, 32'd3);
      check($sformatf("stall_hist_%0d", i), {30'd0, bp_bp_history_o}, 32'd0);
    end
    id_stall_i     = 1'b0;
    bu_bp_update_i = 1'b0;
    lookup(32'h400, 2'd0);
    tick();
    check("stall_update_seen", {30'd0, bp_bp_predict_o}, 32'd0);

    // ---------------- reset mid-sweep ----------------
    rst_ni = 1'b0;
    #1;
    check("async_rst_busy", {31'd0, bp_init_busy_o}, 32'd1);
    check("async_rst_predict", {30'd0, bp_bp_predict_o}, 32'd0);
    tick();
    upd(32'h200, 2'd0, 2'b11, 1'b1);
    @(negedge clk_i);
    rst_ni     = 1'b1;
    n_busy_bad = 0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (bp_init_busy_o !== 1'b1) n_busy_bad++;
    end
    check("busy_first_1000", n_busy_bad, 0);
    rst_ni = 1'b0;
    #1;
    check("midsweep_rst_busy", {31'd0, bp_init_busy_o}, 32'd1);
    tick();
    tick();
    upd(32'h500, 2'd2, 2'b01, 1'b1);
    @(negedge clk_i);
    rst_ni = 1'b1;
    wait_init(n_cyc, n_bad);
    check("resweep_cycles", n_cyc, 4096);
    check("resweep_predict_zero", n_bad, 0);
    bu_bp_update_i = 1'b0;

    lookup(32'h200, 2'd0);
    tick();
    check("reinit_200_h0", {30'd0, bp_bp_predict_o}, 32'd1);
    lookup(32'h500, 2'd2);
    tick();
    check("reinit_500_h2", {30'd0, bp_bp_predict_o}, 32'd1);
    lookup(32'h300, 2'd1);
    tick();
    check("reinit_300_h1", {30'd0, bp_bp_predict_o}, 32'd1);
    lookup(32'h400, 2'd0);
    tick();
    check("reinit_400_h0", {30'd0, bp_bp_predict_o}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
